addr_map_cfg: RTL and testbench

ADDR_MAP_CFG -- requirements
Module: addr_map_cfg

---
 rtl/addr_map_cfg.sv | 161 ++++++++++++++++
 tb/tb_addr_map_cfg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/addr_map_cfg.sv
// Runtime configuration front-end for an address decoder: rules are staged in a
// shadow table, validated rule by rule on COMMIT, then copied into the active map.
module addr_map_cfg #(
    parameter int unsigned NoRules   = 32'd4,
    parameter int unsigned NoIndices = 32'd4,
    parameter int unsigned AddrWidth = 32'd32,
    parameter type         rule_t    = logic,
    parameter int unsigned SelWidth  = (NoRules > 32'd1) ? unsigned'($clog2(NoRules)) : 32'd1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [1:0]            cfg_op_i,
    input  logic [SelWidth-1:0]   cfg_sel_i,
    input  logic [AddrWidth-1:0]  cfg_data_i,
    output logic                  cfg_done_o,
    output logic                  cfg_err_o,
    output rule_t [NoRules-1:0]   addr_map_o,
    output logic                  config_ongoing_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCheck = 2'd1,
        StCopy  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OpWrIdx   = 2'd0,
        OpWrStart = 2'd1,
        OpWrEnd   = 2'd2,
        OpCommit  = 2'd3
    } op_e;

    state_e                state_q, state_d;
    logic [SelWidth-1:0]   cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  map_valid_q, map_valid_d;

    logic [31:0]           sh_idx_q   [NoRules];
    logic [31:0]           sh_idx_d   [NoRules];
    logic [AddrWidth-1:0]  sh_start_q [NoRules];
    logic [AddrWidth-1:0]  sh_start_d [NoRules];
    logic [AddrWidth-1:0]  sh_end_q   [NoRules];
    logic [AddrWidth-1:0]  sh_end_d   [NoRules];
    logic [31:0]           act_idx_q   [NoRules];
    logic [31:0]           act_idx_d   [NoRules];
    logic [AddrWidth-1:0]  act_start_q [NoRules];
    logic [AddrWidth-1:0]  act_start_d [NoRules];
    logic [AddrWidth-1:0]  act_end_q   [NoRules];
    logic [AddrWidth-1:0]  act_end_d   [NoRules];

    logic sel_in_range;
    logic rule_bad;
    logic last_rule;
    op_e  op;

    assign op           = op_e'(cfg_op_i);
    assign sel_in_range = (32'(cfg_sel_i) < NoRules);
    assign last_rule    = (cnt_q == SelWidth'(NoRules - 32'd1));
    // An end address of zero means "open-ended", so only a non-zero end is ordered.
    assign rule_bad     = (sh_idx_q[cnt_q] >= NoIndices) ||
                          ((sh_end_q[cnt_q] != '0) && (sh_start_q[cnt_q] >= sh_end_q[cnt_q]));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        map_valid_d = map_valid_q;
        sh_idx_d    = sh_idx_q;
        sh_start_d  = sh_start_q;
        sh_end_d    = sh_end_q;
        act_idx_d   = act_idx_q;
        act_start_d = act_start_q;
        act_end_d   = act_end_q;

        case (state_q)
            StIdle: begin
                if (cfg_valid_i) begin
                    if (op == OpCommit) begin
                        state_d = StCheck;
                        cnt_d   = '0;
                    end else begin
                        done_d = 1'b1;
                        if (sel_in_range) begin
                            case (op)
                                OpWrIdx:   sh_idx_d[cfg_sel_i]   = 32'(cfg_data_i);
                                OpWrStart: sh_start_d[cfg_sel_i] = cfg_data_i;
                                default:   sh_end_d[cfg_sel_i]   = cfg_data_i;
                            endcase
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            StCheck: begin
                if (rule_bad) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (last_rule) begin
                    state_d = StCopy;
                end else begin
                    cnt_d = cnt_q + SelWidth'(1);
                end
            end
            StCopy: begin
                act_idx_d   = sh_idx_q;
                act_start_d = sh_start_q;
                act_end_d   = sh_end_q;
                map_valid_d = 1'b1;
                state_d     = StIdle;
                done_d      = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            map_valid_q <= 1'b0;
            sh_idx_q    <= '{default: '0};
            sh_start_q  <= '{default: '0};
            sh_end_q    <= '{default: '0};
            act_idx_q   <= '{default: '0};
            act_start_q <= '{default: '0};
            act_end_q   <= '{default: '0};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            map_valid_q <= map_valid_d;
            sh_idx_q    <= sh_idx_d;
            sh_start_q  <= sh_start_d;
            sh_end_q    <= sh_end_d;
            act_idx_q   <= act_idx_d;
            act_start_q <= act_start_d;
            act_end_q   <= act_end_d;
        end
    end

    // Field order matches the rule struct layout: idx, start_addr, end_addr (MSB first).
    for (genvar k = 0; k < NoRules; k++) begin : g_map
        assign addr_map_o[k] = rule_t'({act_idx_q[k], act_start_q[k], act_end_q[k]});
    end

    assign cfg_ready_o      = (state_q == StIdle);
    assign cfg_done_o       = done_q;
    assign cfg_err_o        = err_q;
    assign config_ongoing_o = (state_q != StIdle) || !map_valid_q;

endmodule

// File: tb/tb_addr_map_cfg.sv
// Directed bench for addr_map_cfg: a 4-rule/3-index instance and a 5-rule instance
// (the latter lets an out-of-range rule select be encoded).
module tb_addr_map_cfg;

    typedef struct packed {
        int unsigned idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } rule_t;

    localparam logic [1:0] WR_IDX = 2'd0, WR_START = 2'd1, WR_END = 2'd2, COMMIT = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid4 = 1'b0, valid5 = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [2:0]  sel = 3'd0;
    logic [31:0] data = '0;

    logic        ready4, done4, err4, ongoing4;
    logic        ready5, done5, err5, ongoing5;
    rule_t [3:0] map4;
    rule_t [4:0] map5;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    addr_map_cfg #(
        .NoRules   (32'd4),
        .NoIndices (32'd3),
        .AddrWidth (32'd32),
        .rule_t    (rule_t)
    ) u_dut4 (
        .clk_i            (clk),
        .rst_i            (rst),
        .cfg_valid_i      (valid4),
        .cfg_ready_o      (ready4),
        .cfg_op_i         (op),
        .cfg_sel_i        (sel[1:0]),
        .cfg_data_i       (data),
        .cfg_done_o       (done4),
        .cfg_err_o        (err4),
        .addr_map_o       (map4),
        .config_ongoing_o (ongoing4)
    );

    addr_map_cfg #(
        .NoRules   (32'd5),
        .NoIndices (32'd4),
        .AddrWidth (32'd32),
        .rule_t    (rule_t)
    ) u_dut5 (
        .clk_i            (clk),
        .rst_i            (rst),
        .cfg_valid_i      (valid5),
        .cfg_ready_o      (ready5),
        .cfg_op_i         (op),
        .cfg_sel_i        (sel),
        .cfg_data_i       (data),
        .cfg_done_o       (done5),
        .cfg_err_o        (err5),
        .addr_map_o       (map5),
        .config_ongoing_o (ongoing5)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rule_t mk(input int unsigned i, input logic [31:0] s, input logic [31:0] e);
        return '{idx: i, start_addr: s, end_addr: e};
    endfunction

    // Presents one request for one cycle; returns just after the accepting edge (cycle T+1).
    task automatic issue(input bit d5, input logic [1:0] o, input logic [2:0] s, input logic [31:0] d);
        @(negedge clk);
        check(d5 ? "ready5_before_req" : "ready4_before_req", d5 ? ready5 : ready4, 1'b1);
        op = o; sel = s; data = d;
        if (d5) valid5 = 1'b1; else valid4 = 1'b1;
        @(posedge clk);
        #1;
        valid4 = 1'b0;
        valid5 = 1'b0;
    endtask

    task automatic wr(input bit d5, input logic [1:0] o, input logic [2:0] s, input logic [31:0] d,
                      input bit exp_err);
        issue(d5, o, s, d);
        @(negedge clk);
        check(d5 ? "wr_done5" : "wr_done4", d5 ? done5 : done4, 1'b1);
        check(d5 ? "wr_err5" : "wr_err4", d5 ? err5 : err4, exp_err);
    endtask

    // fail_at < 0: commit expected to succeed; otherwise index of the first bad rule.
    task automatic commit(input bit d5, input int nrules, input int fail_at);
        logic prev_ongoing;
        int   busy;
        @(negedge clk);
        prev_ongoing = d5 ? ongoing5 : ongoing4;
        issue(d5, COMMIT, 3'd0, '0);
        busy = (fail_at < 0) ? nrules + 1 : fail_at + 1;
        for (int k = 1; k <= busy; k++) begin
            @(negedge clk);
            check("commit_busy_ongoing", d5 ? ongoing5 : ongoing4, 1'b1);
            check("commit_busy_done", d5 ? done5 : done4, 1'b0);
        end
        @(negedge clk);
        check("commit_done", d5 ? done5 : done4, 1'b1);
        check("commit_err", d5 ? err5 : err4, (fail_at >= 0));
        check("commit_after_ongoing", d5 ? ongoing5 : ongoing4, (fail_at < 0) ? 1'b0 : prev_ongoing);
        check("commit_after_ready", d5 ? ready5 : ready4, 1'b1);
    endtask

    initial begin
        // Reset and first-cycle state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_map4", map4, '0);
        check("rst_ongoing4", ongoing4, 1'b1);
        check("rst_ready4", ready4, 1'b1);
        check("rst_done4", done4, 1'b0);
        check("rst_ongoing5", ongoing5, 1'b1);

        // Successful commit of rule0 and rule3.
        wr(0, WR_IDX,   3'd0, 32'd1,      0);
        wr(0, WR_START, 3'd0, 32'h1000,   0);
        wr(0, WR_END,   3'd0, 32'h2000,   0);
        wr(0, WR_IDX,   3'd3, 32'd2,      0);
        wr(0, WR_START, 3'd3, 32'h8000,   0);
        check("map_before_commit", map4, '0);
        commit(0, 4, -1);
        check("map3_start", map4[3].start_addr, 32'h8000);
        check("map0", map4[0], mk(1, 32'h1000, 32'h2000));
        check("map3", map4[3], mk(2, 32'h8000, 32'h0));
        check("map1", map4[1], mk(0, 32'h0, 32'h0));
        @(negedge clk);
        check("post_done", done4, 1'b0);
        check("post_ongoing", ongoing4, 1'b0);

        // Rule2 idx out of range: error at T+4, map unchanged.
        wr(0, WR_IDX, 3'd2, 32'd3, 0);
        commit(0, 4, 2);
        check("fail_map0", map4[0], mk(1, 32'h1000, 32'h2000));
        check("fail_map2", map4[2], mk(0, 32'h0, 32'h0));
        check("fail_map3", map4[3], mk(2, 32'h8000, 32'h0));

        // Rule1 start == end; request held during CHECK must wait for IDLE.
        wr(0, WR_IDX,   3'd2, 32'd0,    0);
        wr(0, WR_START, 3'd1, 32'h2000, 0);
        wr(0, WR_END,   3'd1, 32'h2000, 0);
        issue(0, COMMIT, 3'd0, '0);
        op = WR_IDX; sel = 3'd2; data = 32'd1; valid4 = 1'b1;
        @(negedge clk);
        check("hold_ready_t1", ready4, 1'b0);
        check("hold_ongoing_t1", ongoing4, 1'b1);
        @(negedge clk);
        check("hold_ready_t2", ready4, 1'b0);
        check("hold_done_t2", done4, 1'b0);
        @(negedge clk);
        check("eq_done_t3", done4, 1'b1);
        check("eq_err_t3", err4, 1'b1);
        check("eq_ready_t3", ready4, 1'b1);
        check("eq_ongoing_t3", ongoing4, 1'b0);
        @(posedge clk);
        #1 valid4 = 1'b0;
        @(negedge clk);
        check("held_wr_done", done4, 1'b1);
        check("held_wr_err", err4, 1'b0);
        @(negedge clk);
        check("held_wr_single", done4, 1'b0);

        // Repair rule1 and commit; held write to rule2 must be visible.
        wr(0, WR_END, 3'd1, 32'h3000, 0);
        commit(0, 4, -1);
        check("fix_map1", map4[1], mk(0, 32'h2000, 32'h3000));
        check("fix_map2", map4[2], mk(1, 32'h0, 32'h0));

        // Reset during COPY: commit aborted, map cleared, no done pulse.
        issue(0, COMMIT, 3'd0, '0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("rstcopy_ongoing", ongoing4, 1'b1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstcopy_done", done4, 1'b0);
        check("rstcopy_map", map4, '0);
        check("rstcopy_ongoing_after", ongoing4, 1'b1);
        check("rstcopy_ready", ready4, 1'b1);
        @(negedge clk);
        check("rstcopy_done_late", done4, 1'b0);
        // Shadow was cleared too: an all-zero table commits cleanly.
        commit(0, 4, -1);
        check("rstcopy_recommit_map", map4, '0);

        // Five-rule instance: out-of-range selects, failed first commit keeps ongoing high.
        wr(1, WR_START, 3'd5, 32'h1234, 1);
        wr(1, WR_END,   3'd7, 32'h5678, 1);
        wr(1, WR_IDX,   3'd1, 32'd4,    0);
        commit(1, 5, 1);
        check("d5_fail_map", map5, '0);
        wr(1, WR_IDX, 3'd1, 32'd0, 0);
        wr(1, WR_IDX, 3'd4, 32'd2, 0);
        commit(1, 5, -1);
        check("d5_map4", map5[4], mk(2, 32'h0, 32'h0));
        for (int k = 0; k < 4; k++) check("d5_map_low", map5[k], mk(0, 32'h0, 32'h0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of run, expected finish before 200000");
        $fatal(1);
    end

endmodule
